// File: rtl/rf_wb_sched.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_sched
// Description : Write-back scheduler and scoreboard for the 32x32 register
//               file. Shares the single RF write port between the in-order
//               pipeline write-back (priority) and the MDU (valid/ready).
//               Tracks in-flight MDU destinations and stalls issue on RAW/WAW
//               hazards. A starvation counter bounds MDU wait time by holding
//               the pipeline write-back for one cycle.
// Ports       : clk, rst                      - clock, async active-high reset
//               pipe_wr_en_i/adr_i/dt_i       - pipeline write-back request
//               wb_hold_o                     - pipeline must re-present write
//               mdu_valid_i/adr_i/dt_i        - MDU result
//               mdu_ready_o                   - MDU result accepted
//               iss_valid_i/mdu_i/rs1_i/rs2_i/rd_i - issuing instruction
//               iss_stall_o                   - issue must not proceed
//               rf_wr_o/rf_wr_adr_o/rf_wr_dt_o - RF write port
//               sb_err_o                      - sticky scoreboard error
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_sched #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wr_en_i,
  input  logic [4:0]  pipe_wr_adr_i,
  input  logic [31:0] pipe_wr_dt_i,
  output logic        wb_hold_o,
  input  logic        mdu_valid_i,
  output logic        mdu_ready_o,
  input  logic [4:0]  mdu_adr_i,
  input  logic [31:0] mdu_dt_i,
  input  logic        iss_valid_i,
  input  logic        iss_mdu_i,
  input  logic [4:0]  iss_rs1_i,
  input  logic [4:0]  iss_rs2_i,
  input  logic [4:0]  iss_rd_i,
  output logic        iss_stall_o,
  output logic        rf_wr_o,
  output logic [4:0]  rf_wr_adr_o,
  output logic [31:0] rf_wr_dt_o,
  output logic        sb_err_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

  logic [31:1]      pending_q, pending_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             sb_err_q, sb_err_d;

  logic [31:0]      pend_full;
  logic             pipe_real;
  logic             mdu_acc;
  logic             pipe_sel;
  logic             set_en;
  logic             clr_en;

  // x0 is never pending; expose a full 32-bit view so indexing by any
  // 5-bit register number is uniform.
  assign pend_full = {pending_q, 1'b0};

  assign pipe_real   = pipe_wr_en_i & (pipe_wr_adr_i != 5'd0);
  assign wb_hold_o   = ~rst & mdu_valid_i & (starve_q == C_LIMIT);
  assign mdu_ready_o = ~rst & (~pipe_real | wb_hold_o);
  assign mdu_acc     = mdu_valid_i & mdu_ready_o;
  // The pipeline only gets the port when the MDU is not using it and the
  // pipeline is not being held back for a starving MDU result.
  assign pipe_sel    = ~mdu_acc & pipe_real & ~wb_hold_o;

  always_comb begin
    rf_wr_o     = 1'b0;
    rf_wr_adr_o = 5'd0;
    rf_wr_dt_o  = 32'd0;
    if (mdu_acc) begin
      rf_wr_o     = ~rst & (mdu_adr_i != 5'd0);
      rf_wr_adr_o = mdu_adr_i;
      rf_wr_dt_o  = mdu_dt_i;
    end else if (pipe_sel) begin
      rf_wr_o     = ~rst;
      rf_wr_adr_o = pipe_wr_adr_i;
      rf_wr_dt_o  = pipe_wr_dt_i;
    end
  end

  // Registered pending only: an MDU write in this cycle does not release a
  // stall until the next cycle, when the RF read sees the committed value.
  assign iss_stall_o = ~rst & iss_valid_i &
                       (pend_full[iss_rs1_i] | pend_full[iss_rs2_i] |
                        pend_full[iss_rd_i]);

  assign set_en = iss_valid_i & ~iss_stall_o & iss_mdu_i & (iss_rd_i != 5'd0);
  assign clr_en = mdu_acc & (mdu_adr_i != 5'd0);

  // Set and clear cannot collide on one register (a pending rd stalls), so
  // both are applied independently per bit.
  always_comb begin
    pending_d = pending_q;
    for (int i = 1; i < 32; i++) begin
      if (set_en && (iss_rd_i == 5'(i))) pending_d[i] = 1'b1;
      if (clr_en && (mdu_adr_i == 5'(i))) pending_d[i] = 1'b0;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (mdu_acc || !mdu_valid_i) begin
      starve_d = '0;
    end else if (starve_q != C_LIMIT) begin
      starve_d = starve_q + 1'b1;
    end
  end

  assign sb_err_d = sb_err_q | (clr_en & ~pend_full[mdu_adr_i]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      starve_q  <= '0;
      sb_err_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      starve_q  <= starve_d;
      sb_err_q  <= sb_err_d;
    end
  end

  assign sb_err_o = sb_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wb_sched
// Description : Directed self-checking bench for rf_wb_sched
//               (STARVE_LIMIT = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wr_en;
  logic [4:0]  pipe_wr_adr;
  logic [31:0] pipe_wr_dt;
  logic        wb_hold;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_adr;
  logic [31:0] mdu_dt;
  logic        iss_valid;
  logic        iss_mdu;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_stall;
  logic        rf_wr;
  logic [4:0]  rf_wr_adr;
  logic [31:0] rf_wr_dt;
  logic        sb_err;

  int n_checks = 0;
  int n_fail   = 0;

  rf_wb_sched #(.STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_wr_en_i (pipe_wr_en),
    .pipe_wr_adr_i(pipe_wr_adr),
    .pipe_wr_dt_i (pipe_wr_dt),
    .wb_hold_o    (wb_hold),
    .mdu_valid_i  (mdu_valid),
    .mdu_ready_o  (mdu_ready),
    .mdu_adr_i    (mdu_adr),
    .mdu_dt_i     (mdu_dt),
    .iss_valid_i  (iss_valid),
    .iss_mdu_i    (iss_mdu),
    .iss_rs1_i    (iss_rs1),
    .iss_rs2_i    (iss_rs2),
    .iss_rd_i     (iss_rd),
    .iss_stall_o  (iss_stall),
    .rf_wr_o      (rf_wr),
    .rf_wr_adr_o  (rf_wr_adr),
    .rf_wr_dt_o   (rf_wr_dt),
    .sb_err_o     (sb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    pipe_wr_en = 0; pipe_wr_adr = 0; pipe_wr_dt = 0;
    mdu_valid  = 0; mdu_adr     = 0; mdu_dt     = 0;
    iss_valid  = 0; iss_mdu     = 0;
    iss_rs1    = 0; iss_rs2     = 0; iss_rd     = 0;
  endtask

  task automatic issue(input logic mdu, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd);
    iss_valid = 1; iss_mdu = mdu; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd;
  endtask

  task automatic pipe(input logic en, input logic [4:0] adr,
                      input logic [31:0] dt);
    pipe_wr_en = en; pipe_wr_adr = adr; pipe_wr_dt = dt;
  endtask

  task automatic mdu(input logic v, input logic [4:0] adr,
                     input logic [31:0] dt);
    mdu_valid = v; mdu_adr = adr; mdu_dt = dt;
  endtask

  initial begin
    idle();
    rst = 1;
    // MDU offering during reset must not be granted.
    mdu(1, 5'd5, 32'h1);
    #12;
    check("rst_mdu_ready", mdu_ready, 0);
    check("rst_rf_wr", rf_wr, 0);
    check("rst_wb_hold", wb_hold, 0);
    check("rst_sb_err", sb_err, 0);
    idle();
    tick();
    rst = 0;
    #1;
    check("idle_rf_wr", rf_wr, 0);
    check("idle_rf_adr", rf_wr_adr, 0);
    check("idle_rf_dt", rf_wr_dt, 0);
    check("idle_stall", iss_stall, 0);

    // ---------------- RAW on r5 ----------------
    tick();
    issue(1, 5'd1, 5'd2, 5'd5); #1;
    check("raw_issue_mdu", iss_stall, 0);
    tick();
    for (int k = 0; k < 2; k++) begin
      issue(0, 5'd5, 5'd0, 5'd6); #1;
      check("raw_stall", iss_stall, 1);
      tick();
    end
    mdu(1, 5'd5, 32'h1234); #1;
    check("raw_stall_no_bypass", iss_stall, 1);
    check("raw_mdu_ready", mdu_ready, 1);
    check("raw_rf_wr", rf_wr, 1);
    check("raw_rf_adr", rf_wr_adr, 5);
    check("raw_rf_dt", rf_wr_dt, 32'h1234);
    tick();
    mdu(0, 0, 0); #1;
    check("raw_stall_drop", iss_stall, 0);
    check("raw_sb_err", sb_err, 0);

    // ---------------- WAW on r7 ----------------
    tick();
    issue(1, 5'd0, 5'd0, 5'd7); #1;
    check("waw_issue_mdu", iss_stall, 0);
    tick();
    issue(0, 5'd1, 5'd2, 5'd7); #1;
    check("waw_stall", iss_stall, 1);
    issue(1, 5'd0, 5'd0, 5'd0); #1;
    check("mdu_rd0_stall", iss_stall, 0);
    tick();
    issue(0, 5'd0, 5'd0, 5'd0); #1;
    check("rd0_no_pending", iss_stall, 0);
    iss_valid = 0;

    // ---------------- Conflict with pipeline (MDU r7 vs pipe r9) --------
    mdu(1, 5'd7, 32'hAA);
    pipe(1, 5'd9, 32'h99); #1;
    check("cf_mdu_ready", mdu_ready, 0);
    check("cf_rf_adr", rf_wr_adr, 9);
    check("cf_rf_dt", rf_wr_dt, 32'h99);
    check("cf_rf_wr", rf_wr, 1);
    tick();
    pipe(1, 5'd0, 32'h77); #1;
    check("cf_x0_grant", mdu_ready, 1);
    check("cf_x0_rf_adr", rf_wr_adr, 7);
    check("cf_x0_rf_dt", rf_wr_dt, 32'hAA);
    tick();
    idle();
    issue(0, 5'd7, 5'd0, 5'd7); #1;
    check("cf_r7_released", iss_stall, 0);
    check("cf_sb_err", sb_err, 0);

    // ---------------- Starvation with LIMIT=4 ----------------
    issue(1, 5'd0, 5'd0, 5'd3);
    tick();
    idle();
    mdu(1, 5'd3, 32'h33);
    for (int k = 1; k <= 4; k++) begin
      pipe(1, 5'(10 + k), 32'(k)); #1;
      check("stv_deny_ready", mdu_ready, 0);
      check("stv_deny_hold", wb_hold, 0);
      check("stv_deny_adr", rf_wr_adr, 10 + k);
      tick();
    end
    pipe(1, 5'd20, 32'h55); #1;
    check("stv_hold", wb_hold, 1);
    check("stv_grant", mdu_ready, 1);
    check("stv_rf_adr", rf_wr_adr, 3);
    check("stv_rf_dt", rf_wr_dt, 32'h33);
    tick();
    mdu(0, 0, 0); #1;
    check("stv_re_hold", wb_hold, 0);
    check("stv_re_wr", rf_wr, 1);
    check("stv_re_adr", rf_wr_adr, 20);
    check("stv_re_dt", rf_wr_dt, 32'h55);
    tick();
    idle();
    check("stv_sb_err", sb_err, 0);

    // ---------------- Scoreboard error on r12 ----------------
    mdu(1, 5'd12, 32'hC0DE); #1;
    check("sbe_rf_wr", rf_wr, 1);
    check("sbe_rf_adr", rf_wr_adr, 12);
    tick();
    idle(); #1;
    check("sbe_set", sb_err, 1);
    tick(); tick();
    check("sbe_sticky", sb_err, 1);

    // ---------------- Async reset mid-operation ----------------
    issue(1, 5'd0, 5'd0, 5'd4);
    tick();
    issue(1, 5'd0, 5'd0, 5'd8);
    tick();
    idle();
    mdu(1, 5'd4, 32'h44);
    for (int k = 0; k < 2; k++) begin
      pipe(1, 5'(k + 1), 32'(k)); #1;
      check("ar_deny", mdu_ready, 0);
      tick();
    end
    issue(0, 5'd4, 5'd8, 5'd0);
    pipe(1, 5'd2, 32'h2); #1;
    check("ar_pre_stall", iss_stall, 1);
    #1 rst = 1; #1;
    check("ar_rf_wr", rf_wr, 0);
    check("ar_mdu_ready", mdu_ready, 0);
    check("ar_sb_err_clr", sb_err, 0);
    check("ar_stall", iss_stall, 0);
    tick();
    rst = 0;
    idle();
    issue(0, 5'd4, 5'd0, 5'd1); #1;
    check("ar_r4_free", iss_stall, 0);
    issue(0, 5'd0, 5'd8, 5'd1); #1;
    check("ar_r8_free", iss_stall, 0);
    idle();
    mdu(1, 5'd4, 32'h44);
    pipe(1, 5'd1, 32'h1); #1;
    check("ar_starve_clr", wb_hold, 0);
    tick();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
